// File: rtl/axis_frame_sink_pkg.sv
// Shared types and helpers for the AXI-stream frame sink: FSM states and
// tkeep analysis functions used by axis_keep_count.
package axis_frame_sink_pkg;

    // Widest tkeep the helpers accept; narrower masks are zero-extended.
    localparam int KEEP_MAX  = 128;
    localparam int SUM_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } state_t;

    // True when the mask has the form 0..01..1 (all-zero also qualifies).
    function automatic logic keep_contiguous(input logic [KEEP_MAX-1:0] keep);
        return (keep & (keep + KEEP_MAX'(1))) == '0;
    endfunction

    function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] keep);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            cnt = cnt + {7'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_keep_count.sv
// Combinational tkeep analysis: number of kept bytes and contiguity flag.
module axis_keep_count
    import axis_frame_sink_pkg::*;
#(
    parameter int KEEP_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0] tkeep,
    output logic [CNT_WIDTH-1:0]  byte_count,
    output logic                  contiguous
);

    logic [KEEP_MAX-1:0] keep_ext;

    assign keep_ext   = KEEP_MAX'(tkeep);
    assign byte_count = CNT_WIDTH'(popcount(keep_ext));
    assign contiguous = keep_contiguous(keep_ext);

endmodule

// File: rtl/axis_frame_sink.sv
// AXI-stream frame sink: consumes frames and reports per-frame statistics.
// Optional per-frame byte checksum enabled by AXIS_FRAME_SINK_CHECKSUM_EN.
module axis_frame_sink
    import axis_frame_sink_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int MAX_LEN    = 1518,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  pause,
    output logic                  stat_valid,
    output logic [LEN_WIDTH-1:0]  stat_len,
    output logic [ID_WIDTH-1:0]   stat_id,
    output logic [DEST_WIDTH-1:0] stat_dest,
    output logic                  stat_err_user,
    output logic                  stat_err_keep,
    output logic                  stat_err_over,
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
    output logic [SUM_WIDTH-1:0]  stat_sum,
`endif
    output logic [31:0]           frame_count
);

    localparam int CNT_WIDTH = $clog2(KEEP_WIDTH + 1);

    state_t                state_reg, state_next;
    logic                  tready_reg;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic                  kerr_reg;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [DEST_WIDTH-1:0] dest_reg;

    logic                  stat_valid_reg;
    logic [LEN_WIDTH-1:0]  stat_len_reg;
    logic [ID_WIDTH-1:0]   stat_id_reg;
    logic [DEST_WIDTH-1:0] stat_dest_reg;
    logic                  stat_err_user_reg;
    logic                  stat_err_keep_reg;
    logic                  stat_err_over_reg;
    logic [31:0]           frame_count_reg;

    logic [CNT_WIDTH-1:0]  beat_bytes;
    logic                  beat_contig;
    logic                  beat_acc;
    logic                  beat_keep_err;
    logic                  frame_first;
    logic                  frame_done;
    logic                  in_drop;
    logic [LEN_WIDTH-1:0]  len_base;
    logic [LEN_WIDTH:0]    len_sum;
    logic [LEN_WIDTH-1:0]  len_next;
    logic                  kerr_next;
    logic                  over_next;
    logic                  unused_bits;

    axis_keep_count #(
        .KEEP_WIDTH (KEEP_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_keep_count (
        .tkeep      (s_axis_tkeep),
        .byte_count (beat_bytes),
        .contiguous (beat_contig)
    );

    assign beat_acc      = s_axis_tvalid & tready_reg;
    assign beat_keep_err = !beat_contig || (beat_bytes == '0) ||
                           (!s_axis_tlast && (beat_bytes != CNT_WIDTH'(KEEP_WIDTH)));

    // The first beat of a frame restarts every accumulator from zero.
    assign len_base  = frame_first ? '0 : len_reg;
    assign len_sum   = {1'b0, len_base} + (LEN_WIDTH + 1)'(beat_bytes);
    assign len_next  = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
    assign kerr_next = (frame_first ? 1'b0 : kerr_reg) | beat_keep_err;
    assign over_next = 32'(len_next) > 32'(MAX_LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (beat_acc) begin
            case (state_reg)
                IDLE:    state_next = s_axis_tlast ? IDLE : ACTIVE;
                ACTIVE: begin
                    if (s_axis_tlast) begin
                        state_next = IDLE;
                    end else if (over_next) begin
                        state_next = DROP;
                    end
                end
                DROP:    state_next = s_axis_tlast ? IDLE : DROP;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        frame_first = 1'b0;
        in_drop     = 1'b0;
        case (state_reg)
            IDLE:    frame_first = 1'b1;
            DROP:    in_drop     = 1'b1;
            default: ;
        endcase
        frame_done = beat_acc & s_axis_tlast;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tready_reg        <= 1'b0;
            len_reg           <= '0;
            kerr_reg          <= 1'b0;
            id_reg            <= '0;
            dest_reg          <= '0;
            stat_valid_reg    <= 1'b0;
            stat_len_reg      <= '0;
            stat_id_reg       <= '0;
            stat_dest_reg     <= '0;
            stat_err_user_reg <= 1'b0;
            stat_err_keep_reg <= 1'b0;
            stat_err_over_reg <= 1'b0;
            frame_count_reg   <= '0;
        end else begin
            tready_reg     <= !pause;
            stat_valid_reg <= frame_done;
            if (beat_acc) begin
                len_reg  <= len_next;
                kerr_reg <= kerr_next;
                if (frame_first) begin
                    id_reg   <= s_axis_tid;
                    dest_reg <= s_axis_tdest;
                end
            end
            if (frame_done) begin
                stat_len_reg      <= len_next;
                stat_id_reg       <= frame_first ? s_axis_tid : id_reg;
                stat_dest_reg     <= frame_first ? s_axis_tdest : dest_reg;
                stat_err_user_reg <= s_axis_tuser[0];
                stat_err_keep_reg <= kerr_next;
                stat_err_over_reg <= in_drop | over_next;
                frame_count_reg   <= frame_count_reg + 32'd1;
            end
        end
    end

`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
    logic [7:0]           kept_byte [KEEP_WIDTH];
    logic [SUM_WIDTH-1:0] beat_sum;
    logic [SUM_WIDTH-1:0] sum_next;
    logic [SUM_WIDTH-1:0] sum_reg;
    logic [SUM_WIDTH-1:0] stat_sum_reg;

    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_kept
        assign kept_byte[gi] = s_axis_tkeep[gi] ? s_axis_tdata[gi*8 +: 8] : 8'd0;
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_sum = beat_sum + SUM_WIDTH'(kept_byte[i]);
        end
    end

    assign sum_next = (frame_first ? '0 : sum_reg) + beat_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg      <= '0;
            stat_sum_reg <= '0;
        end else begin
            if (beat_acc) begin
                sum_reg <= sum_next;
            end
            if (frame_done) begin
                stat_sum_reg <= sum_next;
            end
        end
    end

    assign stat_sum = stat_sum_reg;
`endif

    // Payload and upper user bits only matter to the optional checksum.
    assign unused_bits = ^{s_axis_tdata, s_axis_tuser};

    assign s_axis_tready = tready_reg;
    assign stat_valid    = stat_valid_reg;
    assign stat_len      = stat_len_reg;
    assign stat_id       = stat_id_reg;
    assign stat_dest     = stat_dest_reg;
    assign stat_err_user = stat_err_user_reg;
    assign stat_err_keep = stat_err_keep_reg;
    assign stat_err_over = stat_err_over_reg;
    assign frame_count   = frame_count_reg;

endmodule

// File: doc/axis_frame_sink.md
AXIS_FRAME_SINK -- requirements
Module: axis_frame_sink

Interface
- REQ-001: Parameter DATA_WIDTH, default 64, tdata width in bits; SHALL be a multiple of 8.
- REQ-002: Parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
- REQ-003: Parameter ID_WIDTH, default 8; DEST_WIDTH, default 8; USER_WIDTH, default 1; each a sideband width.
- REQ-004: Parameter MAX_LEN, default 1518, maximum legal frame length in bytes.
- REQ-005: Parameter LEN_WIDTH, default 16, width of the length counter.
- REQ-006: Ports, with clock and reset first:
  - clk, in, 1: the single clock.
  - rst, in, 1: asynchronous, active-low reset.
  - s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser, in/in/in/out/in/in/in/in, widths per params: AXI stream input.
  - pause, in, 1: holds tready low while high.
  - stat_valid, out, 1: one-cycle frame-complete pulse.
  - stat_len, out, LEN_WIDTH: byte count of the completed frame.
  - stat_id, out, ID_WIDTH; stat_dest, out, DEST_WIDTH: sideband values from the first beat.
  - stat_err_user, out, 1: tuser[0] was set on the last beat.
  - stat_err_keep, out, 1: tkeep was non-contiguous, zero, or partial on a non-last beat.
  - stat_err_over, out, 1: frame length exceeded MAX_LEN.
  - stat_sum, out, 32: byte checksum (only when the macro is defined, see Configuration).
  - frame_count, out, 32: completed frames since reset.

Function
- REQ-007: s_axis_tready SHALL equal !pause && reset-released; it SHALL be registered, so pause takes effect one cycle later.
- REQ-008: A beat is accepted only when tvalid && tready are both high in the same cycle; the block SHALL never drop an accepted beat from its counting.
- REQ-009: State machine states:
  - IDLE: on an accepted beat with tlast=0, go to ACTIVE; with tlast=1, complete a 1-beat frame and stay in IDLE.
  - ACTIVE: on an accepted tlast, complete the frame and go to IDLE; if the running length exceeds MAX_LEN, go to DROP.
  - DROP: keep consuming beats; on tlast, complete the frame with stat_err_over=1 and go to IDLE.
- REQ-010: The per-beat byte count SHALL be the number of set tkeep bits. The length SHALL saturate at all-ones of LEN_WIDTH and never wrap.
- REQ-011: Keep error conditions:
  - Non-last beat whose tkeep is not all-ones.
  - Any beat whose tkeep is not of the form 0..01..1.
  - Beat with tkeep all zero.
  - Once set, the keep error SHALL be sticky until the frame completes.
- REQ-012: stat_* outputs SHALL update, and stat_valid SHALL pulse, the cycle after the accepted tlast beat (latency 1). stat_* SHALL hold their values until the next completion.
- REQ-013: stat_id and stat_dest SHALL be captured on the first accepted beat of the frame.
- REQ-014: frame_count SHALL increment on each stat_valid, including errored frames, and wrap modulo 2^32.
- REQ-015: Back-to-back frames (tlast followed immediately by the next first beat) SHALL be accepted with no bubble. Accumulators SHALL restart cleanly from that first beat.

Reset
- REQ-016: While rst=0:
  - State is IDLE.
  - s_axis_tready=0 and stat_valid=0.
  - All stat_* outputs, frame_count and all accumulators are 0.
- REQ-017: Reset asserted mid-frame SHALL discard the partial frame with no stat_valid. After release, the first accepted beat starts a new frame.

Configuration
- REQ-018: Macro AXIS_FRAME_SINK_CHECKSUM_EN.
  - Defined: stat_sum is the modulo-2^32 sum of all kept bytes of the frame, covering all frame bytes including those received in DROP.
  - Undefined: the stat_sum port is absent and no adder logic exists; all other behaviour is identical.

Structure
- REQ-019: A shared package axis_frame_sink_pkg SHALL hold:
  - the state enum (IDLE, ACTIVE, DROP),
  - the keep-contiguity check function,
  - the popcount function.
- REQ-020: One sub-module, axis_keep_count, SHALL be used. It is combinational and outputs the byte count and a contiguity flag from tkeep.

Verification
- REQ-021: Single-beat frame (tkeep=0x0F, tlast=1, tid=3) -> next cycle: stat_valid=1, stat_len=4, stat_id=3, no errors, frame_count=1.
- REQ-022: 3-beat frame of 0x01 bytes (tkeep FF, FF, 07) -> stat_len=19, stat_sum=19 when the macro is defined.
- REQ-023: Beat 1 of a 2-beat frame has tkeep=0x7F -> stat_err_keep=1, stat_len=15.
- REQ-024: MAX_LEN=16 with a 4x8-byte frame -> stat_err_over=1, stat_len=32, all beats accepted, returns to IDLE.
- REQ-025: pause toggled every 3 cycles during a 10-beat frame -> tready follows pause with a 1-cycle lag, stat_len=80; a back-to-back second frame is accepted with no bubble.
- REQ-026: rst=0 asserted after 2 beats -> no stat_valid, frame_count=0; the next 1-beat frame reports stat_len equal to that beat's keep count only.
